// File: rtl/divider_pkg.sv
// divider_pkg: shared defaults, FSM state encoding and index helper for divider_arbiter.
package divider_pkg;

   localparam int DEF_NUM_REQ        = 4;
   localparam int DEF_DIVIDEND_WIDTH = 32;
   localparam int DEF_DIVISOR_WIDTH  = 16;
   localparam int DEF_DIV_LATENCY    = 34;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT,
      RESP
   } state_e;

   function automatic int wrap_idx(input int base, input int off, input int n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/divider_arbiter_if.sv
// divider_arbiter_if: requester request/response bus plus the external divider link.
interface divider_arbiter_if
   import divider_pkg::*;
#(
   parameter int NUM_REQ        = DEF_NUM_REQ,
   parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
   parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH
) ();

   logic [NUM_REQ-1:0]                     req_valid;
   logic [NUM_REQ-1:0]                     req_ready;
   logic [NUM_REQ-1:0][DIVIDEND_WIDTH-1:0] req_dividend;
   logic [NUM_REQ-1:0][DIVISOR_WIDTH-1:0]  req_divisor;
   logic [NUM_REQ-1:0]                     rsp_valid;
   logic [NUM_REQ-1:0]                     rsp_ready;
   logic [DIVIDEND_WIDTH-1:0]              rsp_quotient;
   logic [DIVISOR_WIDTH-1:0]               rsp_remainder;
   logic                                   rsp_overflow;
   logic                                   div_start;
   logic [DIVIDEND_WIDTH-1:0]              div_dividend;
   logic [DIVISOR_WIDTH-1:0]               div_divisor;
   logic [DIVIDEND_WIDTH-1:0]              div_quotient;
   logic [DIVISOR_WIDTH-1:0]               div_remainder;
   logic                                   div_overflow;

   modport slave (
      input  req_valid, req_dividend, req_divisor, rsp_ready,
             div_quotient, div_remainder, div_overflow,
      output req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_overflow,
             div_start, div_dividend, div_divisor
   );

   modport master (
      output req_valid, req_dividend, req_divisor, rsp_ready,
             div_quotient, div_remainder, div_overflow,
      input  req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_overflow,
             div_start, div_dividend, div_divisor
   );

endinterface

// File: rtl/divider_arbiter_rr.sv
// rr_arbiter: one-hot round-robin grant searching upward from the pointer with wraparound.
module rr_arbiter
   import divider_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IW      = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IW-1:0]      idx_o
);

   logic found;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_i[wrap_idx(int'(ptr_i), i, NUM_REQ)]) begin
            found = 1'b1;
            grant_o[wrap_idx(int'(ptr_i), i, NUM_REQ)] = 1'b1;
            idx_o = IW'(wrap_idx(int'(ptr_i), i, NUM_REQ));
         end
      end
   end

endmodule

// File: rtl/divider_arbiter.sv
// divider_arbiter: shares one fixed-latency external divider among NUM_REQ requesters,
// one operation in flight, round-robin grant, zero divisors answered without the divider.
module divider_arbiter
   import divider_pkg::*;
#(
   parameter int NUM_REQ        = DEF_NUM_REQ,
   parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
   parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH,
   parameter int DIV_LATENCY    = DEF_DIV_LATENCY
) (
   input logic              clk,
   input logic              reset,
   divider_arbiter_if.slave bus
);

   localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;

   state_e                    state_q, state_d;
   logic [IW-1:0]             ptr_q, ptr_d;
   logic [IW-1:0]             grant_q, grant_d;
   logic [7:0]                cnt_q, cnt_d;
   logic [DIVIDEND_WIDTH-1:0] dividend_q, dividend_d;
   logic [DIVISOR_WIDTH-1:0]  divisor_q, divisor_d;
   logic [DIVIDEND_WIDTH-1:0] quo_q, quo_d;
   logic [DIVISOR_WIDTH-1:0]  rem_q, rem_d;
   logic                      ovf_q, ovf_d;
   logic [NUM_REQ-1:0]        arb_grant;
   logic [IW-1:0]             arb_idx;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_rr (
      .req_i   (bus.req_valid),
      .ptr_i   (ptr_q),
      .grant_o (arb_grant),
      .idx_o   (arb_idx)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         grant_q    <= '0;
         cnt_q      <= '0;
         dividend_q <= '0;
         divisor_q  <= '0;
         quo_q      <= '0;
         rem_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         grant_q    <= grant_d;
         cnt_q      <= cnt_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         quo_q      <= quo_d;
         rem_q      <= rem_d;
         ovf_q      <= ovf_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grant_d    = grant_q;
      cnt_d      = cnt_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      quo_d      = quo_q;
      rem_d      = rem_q;
      ovf_d      = ovf_q;
      case (state_q)
         IDLE: begin
            if (|bus.req_valid) begin
               grant_d    = arb_idx;
               dividend_d = bus.req_dividend[arb_idx];
               divisor_d  = bus.req_divisor[arb_idx];
               // Division by zero never reaches the divider; the saturated result is posted directly.
               if (bus.req_divisor[arb_idx] == '0) begin
                  quo_d   = '1;
                  rem_d   = '0;
                  ovf_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  state_d = START;
               end
            end
         end
         START: begin
            cnt_d   = 8'(DIV_LATENCY - 1);
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == '0) begin
               quo_d   = bus.div_quotient;
               rem_d   = bus.div_remainder;
               ovf_d   = bus.div_overflow;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         RESP: begin
            if (bus.rsp_ready[grant_q]) begin
               ptr_d   = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.req_ready     = (state_q == IDLE) ? arb_grant : '0;
   assign bus.rsp_valid     = (state_q == RESP) ? NUM_REQ'(1) << grant_q : '0;
   assign bus.rsp_quotient  = quo_q;
   assign bus.rsp_remainder = rem_q;
   assign bus.rsp_overflow  = ovf_q;
   assign bus.div_start     = state_q == START;
   assign bus.div_dividend  = dividend_q;
   assign bus.div_divisor   = divisor_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// tb_divider_arbiter: directed stimulus with a response scoreboard and a fixed-latency divider stand-in.
module tb_divider_arbiter;
   import divider_pkg::*;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int SW = 16;
   localparam int L  = 34;

   typedef struct {
      int          idx;
      logic [31:0] q;
      logic [15:0] r;
      logic        o;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   errs = 0;
   int   checks = 0;
   int   cyc = 0;
   int   start_cyc = -1000;
   int   n_starts = 0;
   int   last_start = -1;
   exp_t sb[$];
   exp_t mon_e;
   logic div_ok;

   divider_arbiter_if #(.NUM_REQ(N), .DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(SW)) bus ();

   divider_arbiter #(
      .NUM_REQ        (N),
      .DIVIDEND_WIDTH (DW),
      .DIVISOR_WIDTH  (SW),
      .DIV_LATENCY    (L)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Divider stand-in: result is only meaningful in the single cycle DIV_LATENCY after div_start.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.div_start) begin
         start_cyc  <= cyc;
         last_start <= cyc;
         n_starts   <= n_starts + 1;
      end
   end

   assign div_ok            = (cyc == start_cyc + L) && (bus.div_divisor != '0);
   assign bus.div_quotient  = div_ok ? bus.div_dividend / DW'(bus.div_divisor) : 32'hDEADBEEF;
   assign bus.div_remainder = div_ok ? SW'(bus.div_dividend % DW'(bus.div_divisor)) : 16'hDEAD;
   assign bus.div_overflow  = !div_ok;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && (bus.rsp_valid & bus.rsp_ready) != '0) begin
         if (sb.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexpected_rsp: got rsp_valid %0h expected none", bus.rsp_valid);
         end else begin
            mon_e = sb.pop_front();
            chk("rsp_valid_onehot", bus.rsp_valid, 64'(1) << mon_e.idx);
            chk("rsp_quotient", bus.rsp_quotient, mon_e.q);
            chk("rsp_remainder", bus.rsp_remainder, mon_e.r);
            chk("rsp_overflow", bus.rsp_overflow, mon_e.o);
         end
      end
   end

   // Called just after a rising edge with the DUT in IDLE; returns the accept cycle.
   task automatic issue(input int idx, input logic [31:0] dvd, input logic [15:0] dvs, input bit push,
                        input logic [31:0] eq, input logic [15:0] er, input logic eo, output int t);
      bus.req_valid[idx]    = 1'b1;
      bus.req_dividend[idx] = dvd;
      bus.req_divisor[idx]  = dvs;
      @(negedge clk);
      t = cyc;
      chk("req_ready_grant", bus.req_ready, 64'(1) << idx);
      if (push) sb.push_back('{idx, eq, er, eo});
      @(posedge clk);
      #1;
      bus.req_valid[idx]    = 1'b0;
      bus.req_dividend[idx] = 32'h5A5A5A5A;
      bus.req_divisor[idx]  = 16'h0;
   endtask

   task automatic wait_rsp(input int idx, input int t, input int lat);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.rsp_valid[idx]) break;
      end
      chk("rsp_latency", cyc - t, lat);
   endtask

   task automatic chk_idle_outputs();
      chk("idle_req_ready", bus.req_ready, 0);
      chk("idle_rsp_valid", bus.rsp_valid, 0);
      chk("idle_div_start", bus.div_start, 0);
      chk("idle_rsp_quotient", bus.rsp_quotient, 0);
      chk("idle_rsp_remainder", bus.rsp_remainder, 0);
      chk("idle_rsp_overflow", bus.rsp_overflow, 0);
   endtask

   initial begin
      logic [31:0] f_dvd [N] = '{32'd1000, 32'd1017, 32'd1034, 32'd1051};
      logic [15:0] f_dvs [N] = '{16'd3, 16'd4, 16'd5, 16'd6};
      logic [31:0] f_q   [N] = '{32'd333, 32'd254, 32'd206, 32'd175};
      logic [15:0] f_r   [N] = '{16'd1, 16'd1, 16'd4, 16'd1};
      int t, n0, seen, prev_t;
      reset            = 1'b1;
      bus.req_valid    = '0;
      bus.req_dividend = '0;
      bus.req_divisor  = '0;
      bus.rsp_ready    = '1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk_idle_outputs();
      @(posedge clk);
      #1;
      n0 = n_starts;
      issue(0, 32'd100, 16'd7, 1'b1, 32'd14, 16'd2, 1'b0, t);
      wait_rsp(0, t, L + 2);
      @(posedge clk);
      #1;
      chk("div_start_cycle", last_start, t + 1);
      chk("div_start_count", n_starts - n0, 1);
      issue(0, 32'hFFFFFFFF, 16'h0010, 1'b1, 32'h0FFFFFFF, 16'hF, 1'b0, t);
      wait_rsp(0, t, L + 2);
      @(posedge clk);
      #1;
      n0 = n_starts;
      issue(2, 32'h1234, 16'h0, 1'b1, 32'hFFFFFFFF, 16'h0, 1'b1, t);
      wait_rsp(2, t, 1);
      @(posedge clk);
      #1;
      chk("zero_div_no_start", n_starts - n0, 0);
      bus.rsp_ready = 4'b1101;
      issue(1, 32'd1000, 16'd3, 1'b1, 32'd333, 16'd1, 1'b0, t);
      wait_rsp(1, t, L + 2);
      bus.req_valid[3]    = 1'b1;
      bus.req_dividend[3] = 32'd77;
      bus.req_divisor[3]  = 16'd5;
      repeat (10) begin
         @(negedge clk);
         chk("stall_hold", {bus.rsp_valid, bus.rsp_quotient, bus.rsp_remainder, bus.req_ready},
             {4'b0010, 32'd333, 16'd1, 4'b0000});
      end
      @(posedge clk);
      #1;
      bus.req_valid[3] = 1'b0;
      bus.rsp_ready    = '1;
      @(posedge clk);
      #1;
      issue(0, 32'd500, 16'd7, 1'b0, 32'd0, 16'd0, 1'b0, t);
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk_idle_outputs();
      seen = 0;
      repeat (50) begin
         @(negedge clk);
         if (bus.rsp_valid != '0) seen++;
      end
      chk("aborted_no_rsp", seen, 0);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         bus.req_valid[i]    = 1'b1;
         bus.req_dividend[i] = f_dvd[i];
         bus.req_divisor[i]  = f_dvs[i];
      end
      prev_t = 0;
      for (int k = 0; k < 5; k++) begin
         for (int w = 0; w < 100; w++) begin
            @(negedge clk);
            if (bus.req_ready != '0) break;
         end
         chk("fair_grant", bus.req_ready, 64'(1) << (k % N));
         sb.push_back('{k % N, f_q[k % N], f_r[k % N], 1'b0});
         if (k > 0) chk("grant_spacing", cyc - prev_t, L + 3);
         prev_t = cyc;
         @(posedge clk);
         #1;
      end
      bus.req_valid = '0;
      for (int w = 0; w < 100 && sb.size() != 0; w++) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/divider_arbiter.md
DIVIDER_ARBITER -- requirements
Module: divider_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one divider.
REQ-002 SHALL have parameter DIVIDEND_WIDTH, default 32, dividend/quotient width.
REQ-003 SHALL have parameter DIVISOR_WIDTH, default 16, divisor/remainder width.
REQ-004 SHALL have parameter DIV_LATENCY, default 34: cycles from the div_start cycle until the divider outputs are valid (range 1..255).
REQ-005 SHALL have port clk, input, 1, the only clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port req_valid, input, NUM_REQ, per-requester operation request.
REQ-008 SHALL have port req_ready, output, NUM_REQ, per-requester accept (one-hot or zero).
REQ-009 SHALL have port req_dividend, input, NUM_REQ x DIVIDEND_WIDTH, per-requester dividend.
REQ-010 SHALL have port req_divisor, input, NUM_REQ x DIVISOR_WIDTH, per-requester divisor.
REQ-011 SHALL have port rsp_valid, output, NUM_REQ, per-requester result valid (one-hot or zero).
REQ-012 SHALL have port rsp_ready, input, NUM_REQ, per-requester result accept.
REQ-013 SHALL have ports rsp_quotient (DIVIDEND_WIDTH), rsp_remainder (DIVISOR_WIDTH), rsp_overflow (1), outputs, shared result bus.
REQ-014 SHALL have ports div_start (1), div_dividend (DIVIDEND_WIDTH), div_divisor (DIVISOR_WIDTH), outputs to the divider.
REQ-015 SHALL have ports div_quotient (DIVIDEND_WIDTH), div_remainder (DIVISOR_WIDTH), div_overflow (1), inputs from the divider.

Function
REQ-016 SHALL implement FSM states IDLE, START, WAIT, RESP.
REQ-017 IDLE: if any req_valid, SHALL grant one requester round-robin starting at rr_ptr, assert req_ready for it combinationally in that cycle, latch its operands and index, go to START; otherwise stay.
REQ-018 If the latched divisor is zero, SHALL bypass the divider: go directly to RESP with quotient all-ones, remainder 0, overflow 1.
REQ-019 START: SHALL assert div_start for exactly one cycle, load counter with DIV_LATENCY-1, go to WAIT.
REQ-020 WAIT: SHALL decrement counter each cycle; at counter 0 SHALL register div_quotient/div_remainder/div_overflow and go to RESP.
REQ-021 RESP: SHALL assert rsp_valid[grant] with stable result until rsp_ready[grant]; on handshake SHALL set rr_ptr = grant+1 (mod NUM_REQ) and go to IDLE.
REQ-022 Latency: request accept at cycle T, div_start at T+1, rsp_valid first at T+2+DIV_LATENCY; zero-divisor rsp_valid at T+1.
REQ-023 div_dividend/div_divisor SHALL come from the operand latch and stay stable from START until leaving WAIT.
REQ-024 req_ready SHALL be 0 outside IDLE; only one operation in flight.
REQ-025 req_valid deassertion or operand change after acceptance SHALL not affect the running operation.
REQ-026 rsp_ready of non-granted requesters SHALL be ignored.
REQ-027 Back-to-back: after RESP handshake, next grant SHALL occur no earlier than the following IDLE cycle.

Reset
REQ-028 On reset SHALL enter IDLE, rr_ptr=0, counter=0, clear latches; req_ready, rsp_valid, div_start, rsp_* SHALL read 0.
REQ-029 Reset during START/WAIT/RESP SHALL abort the operation; its late divider result SHALL be discarded and no rsp_valid issued.

Structure
REQ-030 Shared package divider_pkg SHALL hold width defaults, DIV_LATENCY default and the FSM state enum.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (inputs request vector, pointer; output one-hot grant).

Verification
REQ-032 Single request: req0 100/7, DIV_LATENCY=34 -> div_start at T+1, rsp_valid[0] at T+36, q=14, r=2, overflow=0.
REQ-033 Fairness: all four requesters valid continuously -> grants 0,1,2,3,0 in order.
REQ-034 Zero divisor: req2 dividend 0x1234, divisor 0 -> no div_start, rsp_valid[2] at T+1, q=0xFFFFFFFF, r=0, overflow=1.
REQ-035 Backpressure: rsp_ready[1] held low 10 cycles -> rsp_valid[1] and result stable, req_ready all 0 throughout.
REQ-036 Large value: 0xFFFFFFFF/0x0010 -> q=0x0FFFFFFF, r=0xF.
REQ-037 Reset in WAIT -> next cycle IDLE, all outputs 0, no response for aborted request; next request from req0 served normally.
